counter_gate_ctrl: RTL
======================

Name: counter_gate_ctrl

Overview:
- Gate-window controller sitting directly downstream of the 16-bit input capture counter.
- Drives the counter's clear and count-enable inputs, times a programmable gate window in system clocks, and latches the final count plus an overflow flag into a result register.
- Hands the result to the host/bus side with a valid/ack handshake. Supports single-shot and continuous (back-to-back) measurement.

Parameters:
- CNT_W, 16, width of the counter value and of the result.
- GATE_W, 24, width of the gate-length value in clock cycles.

Ports:
- i_sysclk  in  1  system clock; all logic on rising edge
- i_sysrst  in  1  asynchronous, active-high reset
- i_start  in  1  start-measurement pulse; honoured only in IDLE
- i_stop  in  1  abort; highest priority after reset
- i_cont  in  1  continuous mode; sampled at end of SETTLE
- i_gate_len  in  GATE_W  gate length in cycles; sampled on entry to CLR; 0 treated as 1
- i_ic_flg  in  1  rising-edge pulse from the counter
- i_cnt  in  CNT_W  current counter value
- o_cnt_clr  out  1  counter clear (registered)
- o_cnt_en  out  1  counter enable (registered)
- o_busy  out  1  high in any state other than IDLE
- o_res  out  CNT_W  latched count
- o_res_ovf  out  1  counter wrapped during this window
- o_res_lost  out  1  a result was overwritten before ack
- o_res_vld  out  1  result valid
- i_res_ack  in  1  consumes the result

Behaviour:
- Reset (async): state=IDLE; all outputs 0; gate timer 0; ovf tracker 0.
- FSM states: IDLE, CLR, GATE, SETTLE.
  - IDLE: if i_start & ~i_stop -> CLR.
  - CLR: lasts 1 cycle. o_cnt_clr=1, o_cnt_en=0. Timer loaded with max(i_gate_len,1)-1. Ovf tracker cleared. -> GATE.
  - GATE: o_cnt_en=1. Timer decrements each cycle; at timer==0 -> SETTLE. o_cnt_en is high for exactly max(len,1) cycles.
  - SETTLE: lasts 1 cycle, o_cnt_en=0. It lets the increment from the last GATE cycle land in i_cnt. At the end of SETTLE, o_res<=i_cnt, o_res_ovf<=tracker, o_res_vld<=1. Then -> CLR if i_cnt sampled... correction: -> CLR if i_cont=1, else -> IDLE.
- Timing: i_start high in cycle 0 gives o_cnt_clr high in cycle 1, o_cnt_en high in cycles 2..N+1, SETTLE in cycle N+2, and o_res_vld high from cycle N+3.
- Continuous-mode dead time is 2 cycles (SETTLE+CLR) per window. Edges arriving in those cycles are not counted.
- o_cnt_clr and o_cnt_en are mutually exclusive and decoded as registered outputs from next-state.
- Overflow: in GATE, if i_ic_flg=1 and i_cnt=all-ones, set tracker (sticky for the window). A wrapped result reports the low CNT_W bits with ovf=1.
- Handshake:
  - o_res_vld stays high until i_res_ack is sampled high while o_res_vld=1. Then vld, ovf and lost clear next cycle.
  - If a new latch and an ack occur in the same cycle, the new result wins: vld stays 1 and lost=0.
  - A new latch while vld=1 with no ack overwrites o_res/o_res_ovf and sets o_res_lost=1.
  - Ack while vld=0 is ignored.
- i_stop: from any state -> IDLE next cycle; o_cnt_en/o_cnt_clr drop next cycle. No result is latched, and existing o_res/vld are unaffected.
- i_start outside IDLE is ignored. i_start and i_stop together: stop wins.
- Changes to i_gate_len mid-window have no effect until the next CLR.

Decomposition:
- Shared package counter_pkg holds:
  - state enum (IDLE, CLR, GATE, SETTLE)
  - CNT_W and GATE_W defaults
  - all-ones count constant
- One sub-module is natural: gate_timer. It is a loadable GATE_W down-counter with load, dec and zero outputs. The FSM, overflow tracker and result/handshake register stay in the top level.

Test Plan:
- Reset mid-GATE (len=100, assert i_sysrst at cycle 50): all outputs go to 0 asynchronously, state IDLE; a later i_start gives a normal window.
- len=10, 3 edges inside the gate: clr at cycle 1, en at cycles 2..11, o_res=3, ovf=0, vld at cycle 13; ack -> vld=0 next cycle.
- len=0: en high for exactly 1 cycle; an edge in that cycle gives o_res=1.
- Edge landing in the last GATE cycle is counted (o_res includes it). Edges in the CLR or SETTLE cycles are not counted.
- Counter preset path: 65537 edges in the window gives o_res=1, o_res_ovf=1.
- Continuous, len=5, no ack: second result sets o_res_lost=1 with the newer count; simultaneous ack+latch gives vld=1, lost=0. i_stop at cycle 4 -> en low at cycle 5, no new vld.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared state type, width defaults and constants for the gate controller
package counter_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int GATE_W_DEF = 24;

    localparam logic [CNT_W_DEF-1:0] CNT_ONES = '1;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        GATE,
        SETTLE
    } state_t;

endpackage

// File: rtl/counter_gate_ctrl_gate_timer.sv
// gate_timer: loadable down-counter that times the gate window
module gate_timer #(
    parameter int W = 24
) (
    input  logic         i_sysclk,
    input  logic         i_sysrst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_sysclk or posedge i_sysrst)
        if (i_sysrst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec)
            cnt <= cnt - W'(1);

    assign zero = cnt == '0;

endmodule

// File: rtl/counter_gate_ctrl.sv
// counter_gate_ctrl: gates the capture counter for a timed window and hands the count to the host
module counter_gate_ctrl
    import counter_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int GATE_W = GATE_W_DEF
) (
    input  logic              i_sysclk,
    input  logic              i_sysrst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_cont,
    input  logic [GATE_W-1:0] i_gate_len,
    input  logic              i_ic_flg,
    input  logic [CNT_W-1:0]  i_cnt,
    output logic              o_cnt_clr,
    output logic              o_cnt_en,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_res,
    output logic              o_res_ovf,
    output logic              o_res_lost,
    output logic              o_res_vld,
    input  logic              i_res_ack
);

    state_t state, state_nxt;
    logic clr_nxt, en_nxt, tmr_zero, trk, latch;
    logic [GATE_W-1:0] len_m1;

    // a zero length still opens the gate for one cycle
    assign len_m1 = (i_gate_len == '0) ? '0 : i_gate_len - GATE_W'(1);

    gate_timer #(.W(GATE_W)) u_timer (
        .i_sysclk (i_sysclk),
        .i_sysrst (i_sysrst),
        .load     (state_nxt == CLR),
        .dec      (state == GATE && !tmr_zero),
        .load_val (len_m1),
        .zero     (tmr_zero)
    );

    always_ff @(posedge i_sysclk or posedge i_sysrst)
        if (i_sysrst) begin
            state     <= IDLE;
            o_cnt_clr <= 1'b0;
            o_cnt_en  <= 1'b0;
        end else begin
            state     <= state_nxt;
            o_cnt_clr <= clr_nxt;
            o_cnt_en  <= en_nxt;
        end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_start ? CLR : IDLE;
            CLR:     state_nxt = GATE;
            GATE:    state_nxt = tmr_zero ? SETTLE : GATE;
            SETTLE:  state_nxt = i_cont ? CLR : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (i_stop)
            state_nxt = IDLE;
    end

    always_comb begin
        clr_nxt = state_nxt == CLR;
        en_nxt  = state_nxt == GATE;
        latch   = state == SETTLE && !i_stop;
    end

    assign o_busy = state != IDLE;

    always_ff @(posedge i_sysclk or posedge i_sysrst)
        if (i_sysrst)
            trk <= 1'b0;
        else if (state == CLR)
            trk <= 1'b0;
        else if (state == GATE && i_ic_flg && &i_cnt)
            trk <= 1'b1;

    // a latch coinciding with an ack keeps the new result and is not a loss
    always_ff @(posedge i_sysclk or posedge i_sysrst)
        if (i_sysrst) begin
            o_res      <= '0;
            o_res_ovf  <= 1'b0;
            o_res_lost <= 1'b0;
            o_res_vld  <= 1'b0;
        end else if (latch) begin
            o_res      <= i_cnt;
            o_res_ovf  <= trk;
            o_res_lost <= o_res_vld && !i_res_ack;
            o_res_vld  <= 1'b1;
        end else if (o_res_vld && i_res_ack) begin
            o_res_ovf  <= 1'b0;
            o_res_lost <= 1'b0;
            o_res_vld  <= 1'b0;
        end

endmodule
